// File: rtl/mem_boot_sequencer_if.sv
// Bundle of the stream, external-memory and CPU-control signals around mem_boot_sequencer.
// The master modport is the sequencer side; the slave modport is the environment side.
interface mem_boot_sequencer_if;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [31:0] wdata_ext_2;
  logic [31:0] instruction;
  logic        enable;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [1:0]  test_id;
  logic [31:0] cycle_count;

  modport master (
    input  start, in_valid, in_data, instruction,
    output in_ready, addr_ext, wen_ext, ren_ext, wdata_ext,
           addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
           enable, busy, done, timeout, test_id, cycle_count
  );

  modport slave (
    output start, in_valid, in_data, instruction,
    input  in_ready, addr_ext, wen_ext, ren_ext, wdata_ext,
           addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
           enable, busy, done, timeout, test_id, cycle_count
  );
endinterface

// File: rtl/mem_boot_sequencer.sv
// Preloads DMEM then IMEM from a word stream, enables the CPU after a settle gap,
// and counts run cycles until a STOP instruction or the cycle limit.
module mem_boot_sequencer #(
  parameter int IMEM_WORDS    = 512,
  parameter int DMEM_WORDS    = 1024,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_CYCLES    = 1000000
) (
  input  logic                  clk,
  input  logic                  arst_n,
  mem_boot_sequencer_if.master  bus
);

  localparam int MAX_WORDS = (IMEM_WORDS > DMEM_WORDS) ? IMEM_WORDS : DMEM_WORDS;
  localparam int IDX_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int SET_W     = $clog2(SETTLE_CYCLES + 1);

  localparam logic [IDX_W-1:0] D_LAST   = IDX_W'(DMEM_WORDS - 1);
  localparam logic [IDX_W-1:0] I_LAST   = IDX_W'(IMEM_WORDS - 1);
  localparam logic [31:0]      CYC_LAST = 32'(MAX_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_D = 3'd1;
  localparam logic [2:0] S_LOAD_I = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]       r_state;
  logic [IDX_W-1:0] r_index;
  logic [SET_W-1:0] r_settle;
  logic [31:0]      r_addr_i;
  logic [31:0]      r_wdata_i;
  logic             r_wen_i;
  logic [31:0]      r_addr_d;
  logic [31:0]      r_wdata_d;
  logic             r_wen_d;
  logic [31:0]      r_cycle_count;
  logic             r_timeout;
  logic [1:0]       r_test_id;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_is_stop;
  logic [31:0] w_addr;
  logic        w_unused_instr;

  assign w_in_ready     = (r_state == S_LOAD_D) || (r_state == S_LOAD_I);
  assign w_accept       = bus.in_valid && w_in_ready;
  assign w_is_stop      = (bus.instruction[31:26] == 6'b111110);
  assign w_addr         = {{(30 - IDX_W){1'b0}}, r_index, 2'b00};
  assign w_unused_instr = &{1'b0, bus.instruction[25:2]};

  // The settle counter starts at SETTLE_CYCLES in the cycle that carries the last
  // IMEM write, so exactly SETTLE_CYCLES write-free cycles precede enable.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state       <= S_IDLE;
      r_index       <= '0;
      r_settle      <= '0;
      r_addr_i      <= '0;
      r_wdata_i     <= '0;
      r_wen_i       <= 1'b0;
      r_addr_d      <= '0;
      r_wdata_d     <= '0;
      r_wen_d       <= 1'b0;
      r_cycle_count <= '0;
      r_timeout     <= 1'b0;
      r_test_id     <= '0;
    end else begin
      r_wen_i <= 1'b0;
      r_wen_d <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state       <= S_LOAD_D;
            r_index       <= '0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
            r_test_id     <= '0;
          end
        end
        S_LOAD_D: begin
          if (w_accept) begin
            r_wen_d   <= 1'b1;
            r_addr_d  <= w_addr;
            r_wdata_d <= bus.in_data;
            if (r_index == D_LAST) begin
              r_index <= '0;
              r_state <= S_LOAD_I;
            end else begin
              r_index <= r_index + IDX_W'(1);
            end
          end
        end
        S_LOAD_I: begin
          if (w_accept) begin
            r_wen_i   <= 1'b1;
            r_addr_i  <= w_addr;
            r_wdata_i <= bus.in_data;
            if (r_index == I_LAST) begin
              r_state  <= S_SETTLE;
              r_settle <= SET_W'(SETTLE_CYCLES);
            end else begin
              r_index <= r_index + IDX_W'(1);
            end
          end
        end
        S_SETTLE: begin
          if (r_settle == '0) begin
            r_state <= S_RUN;
          end else begin
            r_settle <= r_settle - SET_W'(1);
          end
        end
        S_RUN: begin
          // STOP takes priority over the cycle limit
          if (w_is_stop) begin
            r_test_id <= bus.instruction[1:0];
            r_state   <= S_DONE;
          end else begin
            r_cycle_count <= r_cycle_count + 32'd1;
            if (r_cycle_count == CYC_LAST) begin
              r_timeout <= 1'b1;
              r_state   <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.addr_ext    = r_addr_i;
  assign bus.wen_ext     = r_wen_i;
  assign bus.ren_ext     = 1'b0;
  assign bus.wdata_ext   = r_wdata_i;
  assign bus.addr_ext_2  = r_addr_d;
  assign bus.wen_ext_2   = r_wen_d;
  assign bus.ren_ext_2   = 1'b0;
  assign bus.wdata_ext_2 = r_wdata_d;
  assign bus.enable      = (r_state == S_RUN);
  assign bus.busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.timeout     = r_timeout;
  assign bus.test_id     = r_test_id;
  assign bus.cycle_count = r_cycle_count;

endmodule

// File: tb/tb_mem_boot_sequencer.sv
// Randomized bench for mem_boot_sequencer: a beat-count based reference model is
// compared against every DUT output on each falling edge, plus directed literal checks.
module tb_mem_boot_sequencer;
  localparam int IW = 4;
  localparam int DW = 2;
  localparam int SC = 1;
  localparam int MC = 10;

  localparam int PH_IDLE   = 0;
  localparam int PH_LOAD   = 1;
  localparam int PH_SETTLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_DONE   = 4;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  bit   chk_on = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  mem_boot_sequencer_if bus ();

  mem_boot_sequencer #(
    .IMEM_WORDS(IW), .DMEM_WORDS(DW), .SETTLE_CYCLES(SC), .MAX_CYCLES(MC)
  ) dut (
    .clk(clk), .arst_n(arst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // reference model
  longint      t = 0;
  longint      m_run_edge;
  int          m_ph, m_beat, m_cyc;
  bit          m_to, m_wen1, m_wen2;
  logic [1:0]  m_tid;
  logic [31:0] m_a1, m_d1, m_a2, m_d2;

  // write log of the current load
  int          n_lg;
  int          lg_port [16];
  logic [31:0] lg_addr [16];
  logic [31:0] lg_data [16];
  longint      lg_t    [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0d)", name, act, exp, t);
  endtask

  task automatic model_reset();
    m_ph = PH_IDLE; m_beat = 0; m_cyc = 0; m_to = 0; m_tid = 0;
    m_wen1 = 0; m_wen2 = 0; m_a1 = 0; m_d1 = 0; m_a2 = 0; m_d2 = 0; m_run_edge = 0;
  endtask

  task automatic model_update();
    t++;
    if (!arst_n) begin
      model_reset();
      return;
    end
    m_wen1 = 0;
    m_wen2 = 0;
    case (m_ph)
      PH_IDLE, PH_DONE: if (bus.start) begin
        m_ph = PH_LOAD; m_beat = 0; m_cyc = 0; m_to = 0; m_tid = 0;
      end
      PH_LOAD: if (bus.in_valid) begin
        if (m_beat < DW) begin
          m_wen2 = 1; m_a2 = 32'(4 * m_beat); m_d2 = bus.in_data;
        end else begin
          m_wen1 = 1; m_a1 = 32'(4 * (m_beat - DW)); m_d1 = bus.in_data;
        end
        m_beat++;
        if (m_beat == DW + IW) begin
          m_ph = PH_SETTLE;
          m_run_edge = t + 1 + SC;  // one write cycle, then SC idle cycles
        end
      end
      PH_SETTLE: if (t == m_run_edge) m_ph = PH_RUN;
      PH_RUN: begin
        if (bus.instruction[31:26] == 6'b111110) begin
          m_tid = bus.instruction[1:0]; m_ph = PH_DONE;
        end else begin
          m_cyc++;
          if (m_cyc == MC) begin m_to = 1; m_ph = PH_DONE; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    chk("in_ready", bus.in_ready, 32'(m_ph == PH_LOAD));
    chk("busy", bus.busy, 32'(m_ph == PH_LOAD || m_ph == PH_SETTLE || m_ph == PH_RUN));
    chk("done", bus.done, 32'(m_ph == PH_DONE));
    chk("enable", bus.enable, 32'(m_ph == PH_RUN));
    chk("wen_ext", bus.wen_ext, 32'(m_wen1));
    chk("wen_ext_2", bus.wen_ext_2, 32'(m_wen2));
    chk("wen_excl", 32'(bus.wen_ext & bus.wen_ext_2), 0);
    chk("ren_ext", bus.ren_ext, 0);
    chk("ren_ext_2", bus.ren_ext_2, 0);
    chk("addr_ext", bus.addr_ext, m_a1);
    chk("wdata_ext", bus.wdata_ext, m_d1);
    chk("addr_ext_2", bus.addr_ext_2, m_a2);
    chk("wdata_ext_2", bus.wdata_ext_2, m_d2);
    chk("timeout", bus.timeout, 32'(m_to));
    chk("test_id", bus.test_id, 32'(m_tid));
    chk("cycle_count", bus.cycle_count, 32'(m_cyc));
  endtask

  always @(negedge clk) if (chk_on) compare_all();

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_nonstop();
    logic [31:0] r;
    r = $urandom;
    if (r[31:26] == 6'b111110) r[31] = 1'b0;
    return r;
  endfunction

  // pat: 0 = continuous valid, 1 = valid pattern 1,0,0 repeating, 2 = random valid and stray starts
  task automatic load_phase(input int pat, input bit fixed_data);
    int guard;
    n_lg = 0;
    guard = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("restart_count_clear", bus.cycle_count, 0);
    chk("restart_busy", bus.busy, 1);
    while (m_ph == PH_LOAD && guard < 300) begin
      case (pat)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = (guard % 3 == 0);
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      bus.in_data = fixed_data ? (32'hA5A5_0000 + 32'(m_beat)) : $urandom;
      bus.start   = (pat == 2) && ($urandom_range(0, 5) == 0);
      step();
      if (n_lg < 16 && bus.wen_ext_2) begin
        lg_port[n_lg] = 2; lg_addr[n_lg] = bus.addr_ext_2; lg_data[n_lg] = bus.wdata_ext_2;
        lg_t[n_lg] = t; n_lg++;
      end
      if (n_lg < 16 && bus.wen_ext) begin
        lg_port[n_lg] = 1; lg_addr[n_lg] = bus.addr_ext; lg_data[n_lg] = bus.wdata_ext;
        lg_t[n_lg] = t; n_lg++;
      end
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    chk("load_finished", 32'(m_ph != PH_LOAD), 1);
    chk("ready_drop_after_last", bus.in_ready, 0);
    chk("write_count", 32'(n_lg), 32'(DW + IW));
  endtask

  task automatic run_phase(input int stop_at, input logic [31:0] stop_word, output int ncyc);
    int guard;
    ncyc = 0;
    guard = 0;
    while (!bus.enable && guard < 40) begin
      // STOP opcodes outside RUN must be ignored
      bus.instruction = ($urandom_range(0, 1) == 1) ? {6'b111110, 26'($urandom)} : rand_nonstop();
      step();
      guard++;
    end
    chk("wait_enable", bus.enable, 1);
    guard = 0;
    while (bus.enable && guard < 40) begin
      ncyc++;
      bus.instruction = (ncyc == stop_at) ? stop_word : rand_nonstop();
      step();
      guard++;
    end
    chk("wait_done", bus.done, 1);
    bus.instruction = rand_nonstop();
    $display("run: cycles=%0d cycle_count=%0d test_id=%0d timeout=%0d",
             ncyc, bus.cycle_count, bus.test_id, bus.timeout);
  endtask

  initial begin
    int n;
    int guard;
    logic [31:0] exp_addr [6];
    int          exp_port [6];
    exp_addr = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h8, 32'hC};
    exp_port = '{2, 2, 1, 1, 1, 1};

    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hDEAD_BEEF;
    bus.instruction = 32'h0;
    model_reset();
    chk_on = 1'b1;

    // reset held with start and valid active
    repeat (3) step();
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_wen_ext_2", bus.wen_ext_2, 0);
    arst_n = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    repeat (4) step();
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);

    // back-to-back load of A0..A5, STOP on the 7th RUN cycle
    load_phase(0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("b2b_port%0d", i), 32'(lg_port[i]), 32'(exp_port[i]));
      chk($sformatf("b2b_addr%0d", i), lg_addr[i], exp_addr[i]);
      chk($sformatf("b2b_data%0d", i), lg_data[i], 32'hA5A5_0000 + 32'(i));
      if (i > 0) chk($sformatf("b2b_consec%0d", i), 32'(lg_t[i] - lg_t[i-1]), 1);
    end
    run_phase(7, 32'hF800_0002, n);
    chk("stop_run_cycles", 32'(n), 7);
    chk("stop_test_id", bus.test_id, 2);
    chk("stop_cycle_count", bus.cycle_count, 6);
    chk("stop_enable", bus.enable, 0);
    chk("stop_timeout", bus.timeout, 0);

    // stalled stream, restart from DONE, no STOP -> timeout
    load_phase(1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stall_addr%0d", i), lg_addr[i], exp_addr[i]);
    end
    run_phase(0, 32'h0, n);
    chk("to_run_cycles", 32'(n), 10);
    chk("to_cycle_count", bus.cycle_count, 10);
    chk("to_timeout", bus.timeout, 1);

    // STOP on the limit cycle wins
    load_phase(2, 1'b0);
    run_phase(10, 32'hF800_0001, n);
    chk("limit_stop_count", bus.cycle_count, 9);
    chk("limit_stop_timeout", bus.timeout, 0);
    chk("limit_stop_test_id", bus.test_id, 1);

    // reset during LOAD_I
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    guard = 0;
    while (m_beat < DW + 1 && guard < 20) begin
      bus.in_data = $urandom;
      step();
      guard++;
    end
    chk("midload_reached", 32'(m_beat), 32'(DW + 1));
    #2 arst_n = 1'b0;
    #1;
    model_reset();
    chk("async_busy", bus.busy, 0);
    chk("async_in_ready", bus.in_ready, 0);
    chk("async_addr_ext", bus.addr_ext, 0);
    chk("async_wen_ext", bus.wen_ext, 0);
    compare_all();
    bus.start = 1'b1;
    repeat (2) step();
    arst_n = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    step();
    load_phase(0, 1'b0);
    chk("reload_port0", 32'(lg_port[0]), 2);
    chk("reload_addr0", lg_addr[0], 0);
    run_phase(3, 32'hF800_0003, n);
    chk("reload_count", bus.cycle_count, 2);

    // randomized sequences
    repeat (25) begin
      load_phase($urandom_range(0, 2), 1'b0);
      run_phase($urandom_range(1, 12), {6'b111110, 26'($urandom)}, n);
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_boot_sequencer.md
Name: mem_boot_sequencer

Overview:
- Sequences a full CPU test run: streams preload words into data memory (DMEM) over the second external port, then into instruction memory (IMEM) over the first.
- Waits a settle interval, asserts the CPU enable, and counts cycles until a STOP instruction (opcode 6'b111110) or a timeout.
- Sits between a word-stream source (host link or preload ROM) and the cpu external memory ports and enable.
- Reports done, timeout, test selector (STOP instr[1:0]) and cycle count.

Parameters:
- IMEM_WORDS, 512, number of IMEM words written per load (addresses 0..4*(IMEM_WORDS-1)).
- DMEM_WORDS, 1024, number of DMEM words written per load.
- SETTLE_CYCLES, 1, idle cycles between the last IMEM write and enable assertion; minimum 1.
- MAX_CYCLES, 1000000, RUN cycle limit before timeout; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load-and-run sequence.
- in_valid  in  1  stream word valid.
- in_ready  out  1  stream word accepted when in_valid and in_ready are both 1.
- in_data  in  32  stream word; all DMEM words first, then all IMEM words.
- addr_ext  out  32  IMEM external address (byte address).
- wen_ext  out  1  IMEM external write enable.
- ren_ext  out  1  IMEM external read enable; tied 0.
- wdata_ext  out  32  IMEM external write data.
- addr_ext_2  out  32  DMEM external address (byte address).
- wen_ext_2  out  1  DMEM external write enable.
- ren_ext_2  out  1  DMEM external read enable; tied 0.
- wdata_ext_2  out  32  DMEM external write data.
- instruction  in  32  instruction currently in the CPU decode stage.
- enable  out  1  CPU enable.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- timeout  out  1  high when the run ended on MAX_CYCLES; valid while done is high.
- test_id  out  2  instruction[1:0] latched at STOP.
- cycle_count  out  32  RUN cycle count.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (arst_n).
- Reset values: all outputs are 0, state is IDLE, word index is 0.
- Reset applied mid-operation aborts immediately; a partially loaded memory is not rewritten until the next start.
- States: IDLE, LOAD_D, LOAD_I, SETTLE, RUN, DONE.
- IDLE: start moves to LOAD_D and clears the index, cycle_count, timeout and test_id.
- DONE: start behaves exactly as in IDLE (restart).
- start is ignored while busy.
- in_ready is a combinational function of state: 1 exactly in LOAD_D and LOAD_I, otherwise 0.
- Write timing: a beat accepted at edge N makes the write registered at edge N, so it is visible during cycle N+1:
  - DMEM beat: wen_ext_2=1, wdata_ext_2=in_data, addr_ext_2=index<<2.
  - IMEM beat: the same on the unsuffixed port.
- In a cycle with no accepted beat, wen drops to 0.
- Address and data hold their last values while wen is 0.
- Only one of wen_ext and wen_ext_2 is high in any cycle.
- Index increments per accepted beat.
- On the beat where index==DMEM_WORDS-1: index clears and the state moves to LOAD_I.
- On the beat where index==IMEM_WORDS-1 in LOAD_I: state moves to SETTLE and the settle counter loads.
- Stream stalls (in_valid=0) simply hold the state; there is no timeout during load.
- SETTLE: waits SETTLE_CYCLES cycles with all wen=0, then moves to RUN.
- RUN: enable=1.
  - Every RUN cycle without STOP increments cycle_count at the edge.
  - STOP condition: instruction[31:26]==6'b111110.
  - On a STOP cycle: test_id<=instruction[1:0], state moves to DONE, cycle_count is not incremented.
  - If cycle_count==MAX_CYCLES-1 and there is no STOP: increment, set timeout=1, move to DONE.
  - STOP and limit in the same cycle: STOP wins and timeout stays 0.
- DONE: enable=0 from the first DONE cycle; done=1; cycle_count, test_id and timeout hold.
- Widths: the index counter is sized to max(IMEM_WORDS,DMEM_WORDS); address = zero-extended index shifted left by 2.
- cycle_count saturates at MAX_CYCLES and never wraps.

Test Plan:
- Reset and idle (IMEM_WORDS=4, DMEM_WORDS=2, SETTLE_CYCLES=1): hold arst_n=0 with in_valid=1 and start pulsed -> all outputs 0 and in_ready=0; after release with no start, state stays IDLE.
- Back-to-back load: start, then 6 words A0..A5 with in_valid continuously 1:
  - DMEM port shows (0x0,A0) then (0x4,A1).
  - IMEM port shows (0x0,A2)…(0xC,A5) in consecutive cycles.
  - wen_ext and wen_ext_2 are never both high; in_ready drops the cycle after A5.
- Stalled stream: in_valid toggles 1,0,0,1… -> wen pulses only on accepted beats, addresses stay contiguous, final state reaches SETTLE then RUN with enable=1.
- STOP detection: drive instruction=0xF8000002 on the 7th RUN cycle -> test_id=2, cycle_count=6, done=1, enable=0 the next cycle, timeout=0.
- Timeout (MAX_CYCLES=10, no STOP) -> DONE after 10 RUN cycles, cycle_count=10, timeout=1; STOP presented on the 10th cycle instead gives cycle_count=9, timeout=0.
- Mid-run reset and restart:
  - arst_n pulsed low during LOAD_I -> outputs clear immediately.
  - A subsequent start reloads from DMEM address 0x0.
  - start pulsed in DONE also restarts and clears cycle_count.
